// File: rtl/row_norm_pkg.sv
//------------------------------------------------------------------------------
// row_norm_pkg : shared types and helpers for the row normaliser
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package row_norm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIV       = 2'd1,
    RECIP_SAT = 2'd2,
    STREAM    = 2'd3
  } state_t;

  localparam int FW_DEFAULT = 8;
  localparam int DIV_CYCLES = 2 * FW_DEFAULT + 1;

  function automatic int div_cycles(input int fw);
    return 2 * fw + 1;
  endfunction

  // Clamp v into the signed range of a w-bit two's complement number.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/recip_div.sv
//------------------------------------------------------------------------------
// recip_div : sequential restoring divider, quot = floor(2^(2*FW) / divisor)
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module recip_div
  import row_norm_pkg::*;
#(
  parameter int FRACTION_WIDTH = 8,
  parameter int RESULT_WIDTH   = 18
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic [RESULT_WIDTH-1:0] i_divisor,
  output logic                    o_done,
  output logic [RESULT_WIDTH-1:0] o_quot
);

  localparam int QW   = div_cycles(FRACTION_WIDTH);
  localparam int CW   = $clog2(QW + 1);
  localparam int REMW = RESULT_WIDTH + 1;

  logic [CW-1:0]           r_cnt;
  logic                    r_busy;
  logic [RESULT_WIDTH-1:0] r_rem;
  logic [RESULT_WIDTH-1:0] r_den;
  logic [QW-1:0]           r_quo;

  logic                    w_bit;
  logic [REMW-1:0]         w_shift;
  logic                    w_ge;
  logic [RESULT_WIDTH-1:0] w_rem_nx;
  logic [QW-1:0]           w_quo_nx;
  logic                    w_sat;

  // The dividend is a single one at bit 2*FW, i.e. the first bit fed in.
  assign w_bit    = (r_cnt == CW'(QW));
  assign w_shift  = {r_rem, w_bit};
  assign w_ge     = (w_shift >= {1'b0, r_den});
  assign w_rem_nx = RESULT_WIDTH'(w_ge ? (w_shift - {1'b0, r_den}) : w_shift);
  assign w_quo_nx = {r_quo[QW-2:0], w_ge};

  assign o_done = r_busy && (r_cnt == CW'(1));
  assign w_sat  = ((64'(w_quo_nx) >> RESULT_WIDTH) != 64'd0);
  assign o_quot = w_sat ? '1 : RESULT_WIDTH'(w_quo_nx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_den  <= '0;
      r_quo  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(QW);
      r_rem  <= '0;
      r_den  <= i_divisor;
      r_quo  <= '0;
    end else if (r_busy) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/row_normalize.sv
//------------------------------------------------------------------------------
// row_normalize : y = gamma*(x-mean)/stddev + beta over one row of N elements
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module row_normalize
  import row_norm_pkg::*;
#(
  parameter int N              = 4,
  parameter int WIDTH          = 8,
  parameter int FRACTION_WIDTH = 8,
  parameter int RESULT_WIDTH   = WIDTH + $clog2(N) + FRACTION_WIDTH,
  parameter int GB_WIDTH       = 16,
  parameter int OUT_WIDTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        stat_valid,
  output logic                        stat_ready,
  input  logic [RESULT_WIDTH-1:0]     stat_avg,
  input  logic [RESULT_WIDTH-1:0]     stat_stddev,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic signed [GB_WIDTH-1:0]  in_gamma,
  input  logic signed [GB_WIDTH-1:0]  in_beta,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_last,
  output logic                        busy
);

  localparam int DW   = RESULT_WIDTH + 1;
  localparam int PW1  = DW + RESULT_WIDTH + 1;
  localparam int PW2  = OUT_WIDTH + GB_WIDTH;
  localparam int CNTW = $clog2(N + 1);

  state_t                      r_state;
  state_t                      w_state_nx;
  logic [RESULT_WIDTH-1:0]     r_avg;
  logic [RESULT_WIDTH-1:0]     r_recip;
  logic [CNTW-1:0]             r_acc;

  logic                        r_s1_valid;
  logic                        r_s1_last;
  logic signed [DW-1:0]        r_s1_diff;
  logic signed [GB_WIDTH-1:0]  r_s1_gamma;
  logic signed [GB_WIDTH-1:0]  r_s1_beta;

  logic                        r_out_valid;
  logic                        r_out_last;
  logic signed [OUT_WIDTH-1:0] r_out_data;

  logic                        w_pipe_en;
  logic                        w_stat_fire;
  logic                        w_in_fire;
  logic                        w_out_fire;
  logic                        w_div_done;
  logic [RESULT_WIDTH-1:0]     w_quot;
  logic [DW-1:0]               w_x_ext;
  logic signed [DW-1:0]        w_diff;
  logic signed [PW1-1:0]       w_prod1;
  logic signed [OUT_WIDTH-1:0] w_norm;
  logic signed [PW2-1:0]       w_prod2;
  logic signed [OUT_WIDTH-1:0] w_y;

  assign w_pipe_en   = !r_out_valid || out_ready;
  assign w_stat_fire = stat_valid && stat_ready;
  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = r_out_valid && out_ready;

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != IDLE) || r_s1_valid || r_out_valid;

  recip_div #(
    .FRACTION_WIDTH (FRACTION_WIDTH),
    .RESULT_WIDTH   (RESULT_WIDTH)
  ) u_recip_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_stat_fire && (stat_stddev != '0)),
    .i_divisor (stat_stddev),
    .o_done    (w_div_done),
    .o_quot    (w_quot)
  );

  always_comb begin
    w_state_nx = r_state;
    stat_ready = 1'b0;
    in_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        stat_ready = 1'b1;
        if (stat_valid) w_state_nx = (stat_stddev != '0) ? DIV : RECIP_SAT;
      end
      DIV:       if (w_div_done) w_state_nx = STREAM;
      RECIP_SAT: w_state_nx = STREAM;
      STREAM: begin
        in_ready = (r_acc < CNTW'(N)) && w_pipe_en;
        if (w_out_fire && r_out_last) w_state_nx = IDLE;
      end
      default:   w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_avg   <= '0;
      r_recip <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_stat_fire) begin
        r_avg <= stat_avg;
        r_acc <= '0;
      end
      if (r_state == DIV && w_div_done) r_recip <= w_quot;
      if (r_state == RECIP_SAT)         r_recip <= '1;
      if (w_in_fire)                    r_acc   <= r_acc + CNTW'(1);
    end
  end

  // Stage 1: centre the element on the row mean in Q.FW.
  assign w_x_ext = DW'(in_data) << FRACTION_WIDTH;
  assign w_diff  = $signed(w_x_ext - {1'b0, r_avg});

  // Stage 2: scale by the reciprocal, then apply gamma/beta, saturating each step.
  assign w_prod1 = PW1'(r_s1_diff) * PW1'($signed({1'b0, r_recip}));
  assign w_norm  = OUT_WIDTH'(sat_signed(64'(w_prod1 >>> FRACTION_WIDTH), OUT_WIDTH));
  assign w_prod2 = PW2'(w_norm) * PW2'(r_s1_gamma);
  assign w_y     = OUT_WIDTH'(sat_signed(64'(w_prod2 >>> FRACTION_WIDTH) + 64'(r_s1_beta), OUT_WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_diff   <= '0;
      r_s1_gamma  <= '0;
      r_s1_beta   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else if (w_pipe_en) begin
      r_s1_valid <= w_in_fire;
      if (w_in_fire) begin
        r_s1_diff  <= w_diff;
        r_s1_gamma <= in_gamma;
        r_s1_beta  <= in_beta;
        r_s1_last  <= (r_acc == CNTW'(N - 1));
      end
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) r_out_data <= w_y;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_row_normalize.sv
//------------------------------------------------------------------------------
// tb_row_normalize : directed scoreboard bench for row_normalize
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_row_normalize;

  localparam int N   = 4;
  localparam int WID = 8;
  localparam int RW  = 18;
  localparam int GBW = 16;
  localparam int OW  = 16;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  stat_valid = 1'b0;
  logic                  stat_ready;
  logic [RW-1:0]         stat_avg = '0;
  logic [RW-1:0]         stat_stddev = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [WID-1:0]        in_data = '0;
  logic signed [GBW-1:0] in_gamma = '0;
  logic signed [GBW-1:0] in_beta = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic signed [OW-1:0]  out_data;
  logic                  out_last;
  logic                  busy;

  row_normalize dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stat_valid  (stat_valid),
    .stat_ready  (stat_ready),
    .stat_avg    (stat_avg),
    .stat_stddev (stat_stddev),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_gamma    (in_gamma),
    .in_beta     (in_beta),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   data;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_out   = 0;
  int   vx[N];
  int   vg[N];
  int   vb[N];
  int   ve[N];

  logic                 hold_pend = 1'b0;
  logic signed [OW-1:0] hold_data;
  logic                 hold_last;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on each handshake, hold check on stalls.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
        check("hold_last", out_last, hold_last);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (out_valid && out_ready) begin
        n_tests++;
        assert (sb.size() > 0)
        else begin
          n_fail++;
          $error("FAIL stray_output observed=%0d expected=no_output", out_data);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_last", out_last, e.last);
          n_out++;
        end
      end
    end
  end

  task automatic check_reset_vals();
    check("rst_stat_ready", stat_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stat_valid = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic stat_handshake(input int avg, input int sd);
    logic ok;
    ok = 1'b0;
    stat_valid  = 1'b1;
    stat_avg    = RW'(avg);
    stat_stddev = RW'(sd);
    for (int w = 0; w < 200; w++) begin
      if (stat_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("stat_handshake", ok, 1);
    @(posedge clk); #1;
    stat_valid = 1'b0;
  endtask

  // Stat handshake then measure cycles until in_ready first rises.
  task automatic send_stat(input int avg, input int sd, input int exp_lat);
    int lat;
    lat = -1;
    stat_handshake(avg, sd);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("stat_ready_low", stat_ready, 0);
        check("busy_high", busy, 1);
      end
      if (in_ready) begin lat = k; break; end
    end
    check("in_ready_latency", lat, exp_lat);
  endtask

  task automatic send_row(input int n);
    logic ok;
    exp_t e;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = vx[i][WID-1:0];
      in_gamma = vg[i][GBW-1:0];
      in_beta  = vb[i][GBW-1:0];
      ok = 1'b0;
      for (int w = 0; w < 100; w++) begin
        if (in_ready) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check("in_handshake", ok, 1);
      e.data = ve[i];
      e.last = (i == N - 1);
      sb.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    check("drain", ok, 1);
    check("drain_stat_ready", stat_ready, 1);
  endtask

  task automatic stall_after_two();
    int   base;
    logic ok;
    base = n_out;
    ok = 1'b0;
    for (int w = 0; w < 100; w++) begin
      @(posedge clk);
      if (n_out >= base + 2) begin ok = 1'b1; break; end
    end
    check("stall_sync", ok, 1);
    #1 out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_data", out_data, 128);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic no_stray(input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (out_valid || in_ready) seen++;
    end
    check("no_stray_after_reset", seen, 0);
    check("post_reset_stat_ready", stat_ready, 1);
  endtask

  task automatic set_t1();
    vx = '{1, 2, 3, 4};
    vg = '{256, 256, 256, 256};
    vb = '{0, 0, 0, 0};
    ve = '{-384, -128, 128, 384};
  endtask

  initial begin
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Basic row, unit stddev; in_ready 18 cycles after the stat handshake.
    set_t1();
    send_stat(640, 256, 18);
    send_row(N);
    drain();

    // Doubled stddev halves the result.
    ve = '{-192, -64, 64, 192};
    send_stat(640, 512, 18);
    send_row(N);
    drain();

    // Gamma and beta applied.
    vg = '{512, 512, 512, 512};
    vb = '{256, 256, 256, 256};
    ve = '{-512, 0, 512, 1024};
    send_stat(640, 256, 18);
    send_row(N);
    drain();

    // Zero stddev: saturated reciprocal, short latency.
    vx = '{4, 0, 0, 0};
    vg = '{256, 256, 256, 256};
    vb = '{0, 0, 0, 0};
    ve = '{32767, 0, 0, 0};
    send_stat(0, 0, 2);
    send_row(N);
    drain();

    // Non-exact reciprocal (85): shifts round toward -inf.
    set_t1();
    ve = '{-128, -43, 42, 127};
    send_stat(640, 768, 18);
    send_row(N);
    drain();

    // Negative gamma, saturation in both stages.
    vx = '{10, 0, 255, 3};
    vg = '{-256, -256, -512, -256};
    vb = '{128, 128, 128, 128};
    ve = '{-1432, 1128, -32768, 360};
    send_stat(1000, 256, 18);
    send_row(N);
    drain();

    // Downstream stall after the second result.
    set_t1();
    send_stat(640, 256, 18);
    fork
      send_row(N);
      stall_after_two();
    join
    drain();

    // Reset while dividing.
    stat_handshake(640, 256);
    repeat (5) @(negedge clk);
    check("div_busy", busy, 1);
    apply_reset();
    no_stray(30);

    // Reset mid-stream.
    set_t1();
    send_stat(640, 256, 18);
    send_row(2);
    apply_reset();
    no_stray(30);

    // Normal row after recovery.
    set_t1();
    send_stat(640, 256, 18);
    send_row(N);
    drain();

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL global_timeout observed=timeout expected=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
